// File: rtl/mem_port_arbiter_if.sv
// Bundle between the arbiter, the pipeline requesters (IF, MEM stage) and the
// single-port memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ready;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rdata, if_stall,
        input  dm_read, dm_write, dm_addr, dm_wdata,
        output dm_ready, dm_rdata, dm_stall,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    // Pipeline and memory side.
    modport master (
        output if_req, if_addr,
        input  if_ready, if_rdata, if_stall,
        output dm_read, dm_write, dm_addr, dm_wdata,
        input  dm_ready, dm_rdata, dm_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage.
// Data has priority; a starvation counter forces a fetch after a run of data grants.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_e;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic dreq;
    logic freq;
    logic force_fetch;

    // Ready masks keep a requester from being re-granted in its completion cycle.
    assign dreq        = (bus.dm_read | bus.dm_write) & ~dm_ready_q;
    assign freq        = bus.if_req & ~if_ready_q;
    assign force_fetch = dreq & freq & (starve_cnt_q == CNT_MAX);

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_ready_d   = 1'b0;
        dm_ready_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (force_fetch || (freq && !dreq)) begin
                    state_d      = FETCH;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = bus.if_addr;
                    starve_cnt_d = '0;
                end else if (dreq) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_write;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    if (freq && (starve_cnt_q != CNT_MAX)) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
            end
            FETCH: begin
                if (bus.mem_ready) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if_ready_d = 1'b1;
                    if_rdata_d = bus.mem_rdata;
                end
            end
            DATA: begin
                if (bus.mem_ready) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    dm_ready_d = 1'b1;
                    // Stores leave the load-data register untouched.
                    if (!mem_we_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_ready_q   <= 1'b0;
            dm_ready_q   <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ready_q   <= if_ready_d;
            dm_ready_q   <= dm_ready_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_stall  = bus.if_req & ~if_ready_q;
    assign bus.dm_stall  = (bus.dm_read | bus.dm_write) & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle reference model,
// vector table, directed corner sequences and a randomized run.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        ir;
        logic        dr;
        logic        dw;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] wd;
        logic        gf;
        logic        we;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [31:0] rd;
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [logic [31:0]];

    // Reference state: owner 0 = none, 1 = fetch, 2 = data.
    int          owner;
    int          starve;
    logic        e_req, e_we, e_ifr, e_dmr;
    logic [31:0] e_addr, e_wd, e_ifd, e_dmd;

    bit   auto_mem = 0;
    int   lat = 0;
    int   wcnt = 0;
    bit   log_en = 0;
    byte  glog [$];
    logic prev_req = 1'b0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memget(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    task automatic model_edge();
        bit pifr;
        bit pdmr;
        bit dq;
        bit fq;
        pifr  = (e_ifr === 1'b1);
        pdmr  = (e_dmr === 1'b1);
        e_ifr = 1'b0;
        e_dmr = 1'b0;
        if (rst) begin
            owner  = 0;
            starve = 0;
            e_req  = 0;
            e_we   = 0;
            e_addr = 0;
            e_wd   = 0;
            e_ifd  = 0;
            e_dmd  = 0;
        end else if (owner != 0) begin
            if (bus.mem_ready === 1'b1) begin
                if (owner == 1) begin
                    e_ifr = 1'b1;
                    e_ifd = bus.mem_rdata;
                end else begin
                    e_dmr = 1'b1;
                    if (!e_we) e_dmd = bus.mem_rdata;
                end
                e_req = 1'b0;
                e_we  = 1'b0;
                owner = 0;
            end
        end else begin
            dq = (bus.dm_read | bus.dm_write) && !pdmr;
            fq = bus.if_req && !pifr;
            if (fq && (!dq || starve == LIMIT)) begin
                owner  = 1;
                e_req  = 1'b1;
                e_we   = 1'b0;
                e_addr = bus.if_addr;
                starve = 0;
            end else if (dq) begin
                owner  = 2;
                e_req  = 1'b1;
                e_we   = bus.dm_write;
                e_addr = bus.dm_addr;
                e_wd   = bus.dm_wdata;
                if (fq && starve < LIMIT) starve++;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("cycle_model",
            {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
             bus.if_ready, bus.if_rdata, bus.if_stall,
             bus.dm_ready, bus.dm_rdata, bus.dm_stall},
            {e_req, e_we, e_addr, e_wd,
             e_ifr, e_ifd, bus.if_req & ~e_ifr,
             e_dmr, e_dmd, (bus.dm_read | bus.dm_write) & ~e_dmr});
        if (log_en && bus.mem_req && !prev_req)
            glog.push_back(bus.mem_addr == 32'h1000 ? 8'h46 : 8'h44);
        prev_req = bus.mem_req;
        if (auto_mem) begin
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
            end else if (bus.mem_req) begin
                if (wcnt >= lat) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = memget(bus.mem_addr);
                    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    endtask

    task automatic clear_reqs();
        bus.if_req   = 0;
        bus.dm_read  = 0;
        bus.dm_write = 0;
    endtask

    vec_t tbl [8];
    byte  starve_exp [10];

    initial begin
        int n;
        rst           = 1'b1;
        bus.if_req    = 0;
        bus.if_addr   = 0;
        bus.dm_read   = 0;
        bus.dm_write  = 0;
        bus.dm_addr   = 0;
        bus.dm_wdata  = 0;
        bus.mem_ready = 0;
        bus.mem_rdata = 0;
        mem[32'h40]  = 32'hDEADBEEF;
        mem[32'h200] = 32'h0BADF00D;
        mem[32'h300] = 32'h11112222;

        //             ir dr dw ia        da        wd            gf we maddr     mwd           rd
        tbl[0] = '{1, 0, 0, 32'h40,  32'h0,   32'h0,        1, 0, 32'h40,  32'h0,        32'hDEADBEEF};
        tbl[1] = '{0, 0, 1, 32'h0,   32'h100, 32'h1234,     0, 1, 32'h100, 32'h1234,     32'h0};
        tbl[2] = '{0, 1, 0, 32'h0,   32'h100, 32'h0,        0, 0, 32'h100, 32'h0,        32'h1234};
        tbl[3] = '{0, 1, 1, 32'h0,   32'h8,   32'hCAFEF00D, 0, 1, 32'h8,   32'hCAFEF00D, 32'h1234};
        tbl[4] = '{1, 0, 0, 32'h200, 32'h0,   32'h0,        1, 0, 32'h200, 32'h0,        32'h0BADF00D};
        tbl[5] = '{1, 1, 0, 32'h40,  32'h300, 32'h0,        0, 0, 32'h300, 32'h0,        32'h11112222};
        tbl[6] = '{1, 0, 0, 32'h8,   32'h0,   32'h0,        1, 0, 32'h8,   32'h0,        32'hCAFEF00D};
        tbl[7] = '{0, 1, 0, 32'h0,   32'h8,   32'h0,        0, 0, 32'h8,   32'h0,        32'hCAFEF00D};

        starve_exp = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h46,
                       8'h44, 8'h44, 8'h44, 8'h44, 8'h46};

        // Reset held with a fetch pending.
        cycle();
        bus.if_req  = 1;
        bus.if_addr = 32'h40;
        repeat (4) begin
            cycle();
            chk("reset_hold",
                {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                 bus.if_ready, bus.if_rdata, bus.dm_ready, bus.dm_rdata}, '0);
        end
        bus.if_req = 0;
        rst        = 1'b0;
        cycle();

        // Vector table.
        auto_mem = 1;
        for (int i = 0; i < 8; i++) begin
            lat          = (i == 0) ? 2 : i % 3;
            bus.if_req   = tbl[i].ir;
            bus.if_addr  = tbl[i].ia;
            bus.dm_read  = tbl[i].dr;
            bus.dm_write = tbl[i].dw;
            bus.dm_addr  = tbl[i].da;
            bus.dm_wdata = tbl[i].wd;
            n = 0;
            do begin cycle(); n++; end while (!bus.mem_req && n < 20);
            chk("vec_grant", bus.mem_req, 1'b1);
            chk("vec_mem_bus",
                {bus.mem_we, bus.mem_addr, tbl[i].gf ? 32'h0 : bus.mem_wdata},
                {tbl[i].we, tbl[i].maddr, tbl[i].mwd});
            n = 0;
            do begin cycle(); n++; end
            while (!(bus.if_ready | bus.dm_ready) && n < 20);
            chk("vec_ready",
                {bus.if_ready, bus.dm_ready,
                 tbl[i].gf ? bus.if_rdata : bus.dm_rdata},
                {tbl[i].gf, !tbl[i].gf, tbl[i].rd});
            cycle();
            chk("vec_regrant", bus.mem_req,
                tbl[i].ir & (tbl[i].dr | tbl[i].dw));
            bus.dm_read  = 0;
            bus.dm_write = 0;
            if (!(tbl[i].ir & (tbl[i].dr | tbl[i].dw))) bus.if_req = 0;
            n = 0;
            while ((bus.mem_req || bus.if_ready) && n < 20) begin
                cycle();
                n++;
                if (bus.if_ready) bus.if_req = 0;
            end
            chk("vec_drain", bus.mem_req, 1'b0);
            cycle();
        end

        // Starvation: both requesters re-raise after every completion bubble.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clear_reqs();
        bus.if_addr = 32'h1000;
        bus.dm_addr = 32'h2000;
        lat         = 1;
        glog.delete();
        log_en      = 1;
        bus.if_req  = 1;
        bus.dm_read = 1;
        n = 0;
        while (glog.size() < 10 && n < 400) begin
            cycle();
            n++;
            if (bus.if_ready | bus.dm_ready) begin
                bus.if_req  = 0;
                bus.dm_read = 0;
            end else begin
                bus.if_req  = 1;
                bus.dm_read = 1;
            end
        end
        log_en = 0;
        chk("starve_count", glog.size(), 10);
        for (int k = 0; k < 10; k++)
            chk("starve_order", (k < glog.size()) ? glog[k] : 8'h0, starve_exp[k]);
        n = 0;
        while ((bus.mem_req || bus.if_ready || bus.dm_ready) && n < 20) begin
            cycle();
            n++;
            if (bus.if_ready) bus.if_req = 0;
            if (bus.dm_ready) bus.dm_read = 0;
        end
        clear_reqs();
        cycle();

        // Reset while a data access is outstanding, then a late mem_ready.
        auto_mem      = 0;
        bus.mem_ready = 0;
        bus.dm_read   = 1;
        bus.dm_addr   = 32'h500;
        n = 0;
        do begin cycle(); n++; end while (!bus.mem_req && n < 20);
        chk("abort_grant", bus.mem_req, 1'b1);
        rst         = 1'b1;
        bus.dm_read = 0;
        cycle();
        chk("abort_req", bus.mem_req, 1'b0);
        rst           = 1'b0;
        bus.mem_ready = 1;
        bus.mem_rdata = 32'h5555AAAA;
        cycle();
        bus.mem_ready = 0;
        chk("abort_late", {bus.dm_ready, bus.if_ready, bus.dm_rdata, bus.mem_req}, '0);
        bus.if_req  = 1;
        bus.if_addr = 32'h600;
        cycle();
        chk("abort_next", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h600});
        bus.mem_ready = 1;
        bus.mem_rdata = 32'h00600600;
        cycle();
        bus.mem_ready = 0;
        bus.if_req    = 0;
        chk("abort_fetch", {bus.if_ready, bus.if_rdata}, {1'b1, 32'h00600600});
        cycle();

        // Randomized traffic against the reference model.
        repeat (3000) begin
            cycle();
            bus.mem_ready = ($urandom_range(0, 2) == 0);
            bus.mem_rdata = $urandom;
            if (owner != 1 && $urandom_range(0, 3) == 0) begin
                bus.if_req  = $urandom_range(0, 1);
                bus.if_addr = $urandom;
            end
            if (owner != 2 && $urandom_range(0, 3) == 0) begin
                bus.dm_read  = $urandom_range(0, 1);
                bus.dm_write = $urandom_range(0, 1);
                bus.dm_addr  = $urandom;
                bus.dm_wdata = $urandom;
            end
            rst = ($urandom_range(0, 249) == 0);
        end
        rst = 1'b0;
        clear_reqs();
        bus.mem_ready = 0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
